// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO for any DEPTH. It provides an occupancy count, almost-full and
// almost-empty thresholds, an optional first-word-fall-through read, and sticky error flags.
module sync_fifo_flags #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 12,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 10,
  parameter int AE_LEVEL = 2,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_en,
  input  logic             read_en,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // A write into a full FIFO is accepted when a read frees a slot in the same cycle.
  assign rd_ok = read_en && !empty;
  assign wr_ok = write_en && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (rd_ok)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new error in the same cycle as a clear takes priority over the clear.
      if (write_en && !wr_ok)
        overflow <= 1'b1;
      else if (err_clr)
        overflow <= 1'b0;
      if (read_en && !rd_ok)
        underflow <= 1'b1;
      else if (err_clr)
        underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = empty ? '0 : mem[rd_ptr];
  end else begin : g_std
    always_ff @(posedge clk) begin
      if (!rst)
        data_out <= '0;
      else if (rd_ok)
        data_out <= mem[rd_ptr];
    end
  end

endmodule
